// File: rtl/switch_pkg.sv
// Shared packet definitions for the switch ingress path.
package switch_pkg;

    localparam int ADDR_W = 48;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } switch_pkt_t;

endpackage

// File: rtl/switch_fifo_ram.sv
// Packet storage for the ingress FIFO: synchronous write, registered read.
// A read of the slot being written in the same cycle returns the new packet.
module switch_fifo_ram
    import switch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  switch_pkt_t   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output switch_pkt_t   rdata_o
);

    switch_pkt_t mem [DEPTH];
    switch_pkt_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i)
            mem[waddr_i] <= wdata_i;
    end

    // rdata only moves on re_i, so it holds the last popped packet when idle
    always_ff @(posedge clk) begin
        if (reset)
            rdata_q <= '0;
        else if (re_i)
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/switch_ingress_buffer.sv
// Ingress FIFO in front of the switch core; drops null-address packets.
// Define SWITCH_INGRESS_STATS_EN to add saturating accept/drop counters.
module switch_ingress_buffer
    import switch_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [ADDR_W-1:0] src_addr,
    output logic [DATA_W-1:0] src_data,
    output logic [LW-1:0]     level
`ifdef SWITCH_INGRESS_STATS_EN
   ,output logic [CNT_W-1:0]  accept_cnt,
    output logic [CNT_W-1:0]  drop_cnt
`endif
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          in_ready_q, src_valid_q;
    logic          push, pop;
    switch_pkt_t   head;

    assign push = in_valid && in_ready_q && (in_addr != NULL_ADDR);
    assign pop  = src_valid_q && src_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      level_d = level_q + LW'(1);
            else if (pop && !push) level_d = level_q - LW'(1);
        end
    end

    // Handshake flags are registered from the next occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            src_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= (level_d != LW'(DEPTH));
            src_valid_q <= (level_d != '0);
        end
    end

    // Reading at the next head pointer keeps src_* aligned with src_valid
    switch_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i ('{addr: in_addr, data: in_data}),
        .re_i    (level_d != '0),
        .raddr_i (rd_ptr_d),
        .rdata_o (head)
    );

    assign in_ready  = in_ready_q;
    assign src_valid = src_valid_q;
    assign src_addr  = head.addr;
    assign src_data  = head.data;
    assign level     = level_q;

`ifdef SWITCH_INGRESS_STATS_EN
    logic             drop;
    logic [CNT_W-1:0] accept_cnt_q, drop_cnt_q;

    assign drop = in_valid && in_ready_q && (in_addr == NULL_ADDR);

    // Accepts count only packets actually queued, so a flushed push is not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            accept_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            if (push && !flush && (accept_cnt_q != '1))
                accept_cnt_q <= accept_cnt_q + CNT_W'(1);
            if (drop && (drop_cnt_q != '1))
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign accept_cnt = accept_cnt_q;
    assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_ingress_buffer.sv
// Scoreboard bench for switch_ingress_buffer; honours SWITCH_INGRESS_STATS_EN.
module tb_switch_ingress_buffer;
    import switch_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              src_ready = 1'b0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, src_valid;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_data;
    logic [LW-1:0]     level;
`ifdef SWITCH_INGRESS_STATS_EN
    logic [CNT_W-1:0]  accept_cnt, drop_cnt;
`endif

    always #5 clk = ~clk;

    switch_ingress_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .level      (level)
`ifdef SWITCH_INGRESS_STATS_EN
       ,.accept_cnt (accept_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    switch_pkt_t exp_q[$];
    int mdl_level = 0;
    int mdl_acc   = 0;
    int mdl_drop  = 0;
    bit armed     = 1'b0;
    int n_vec     = 0;
    int n_err     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue one cycle of stimulus; packets the buffer will queue go to the scoreboard
    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic sr, input logic fl);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        src_ready = sr;
        flush     = fl;
        if (v && !fl && !reset && (mdl_level < DEPTH) && (a != NULL_ADDR))
            exp_q.push_back('{addr: a, data: d});
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares outputs on the falling edge, then advances the occupancy model
    always @(negedge clk) begin
        bit pu, dr, po;
        if (armed) begin
            chk("level", 64'(level), 64'(mdl_level));
            chk("in_ready", 64'(in_ready), 64'(mdl_level != DEPTH));
            chk("src_valid", 64'(src_valid), 64'(mdl_level != 0));
`ifdef SWITCH_INGRESS_STATS_EN
            chk("accept_cnt", 64'(accept_cnt), 64'(mdl_acc));
            chk("drop_cnt", 64'(drop_cnt), 64'(mdl_drop));
`endif
            if (mdl_level != 0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL head: scoreboard empty, got addr %0h", src_addr);
                end else begin
                    chk("src_addr", 64'(src_addr), 64'(exp_q[0].addr));
                    chk("src_data", 64'(src_data), 64'(exp_q[0].data));
                    if (src_ready && !flush && !reset)
                        void'(exp_q.pop_front());
                end
            end
        end
        if (reset) begin
            mdl_level = 0;
            mdl_acc   = 0;
            mdl_drop  = 0;
            exp_q.delete();
            armed     = 1'b1;
        end else begin
            pu = in_valid && (mdl_level != DEPTH) && (in_addr != NULL_ADDR);
            dr = in_valid && (mdl_level != DEPTH) && (in_addr == NULL_ADDR);
            po = (mdl_level != 0) && src_ready;
            if (dr && mdl_drop < 65535) mdl_drop++;
            if (flush) begin
                mdl_level = 0;
                exp_q.delete();
            end else begin
                if (pu && mdl_acc < 65535) mdl_acc++;
                mdl_level = mdl_level + int'(pu) - int'(po);
            end
        end
    end

    initial begin
        int i, cyc;
        logic sr;

        // Reset held three cycles
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_src_valid", 64'(src_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_src_addr", 64'(src_addr), 64'd0);
        chk("rst_src_data", 64'(src_data), 64'd0);
`ifdef SWITCH_INGRESS_STATS_EN
        chk("rst_accept", 64'(accept_cnt), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
`endif
        reset = 1'b0;

        // Fill to full with the sink stalled, then drain
        for (int k = 1; k <= 8; k++)
            drive(1'b1, 48'(k), 32'hA0 + 32'(k - 1), 1'b0, 1'b0);
        chk("fill_level", 64'(level), 64'd8);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        repeat (8) drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_hold_addr", 64'(src_addr), 64'h8);
        chk("drain_hold_data", 64'(src_data), 64'hA7);

        // Null address between two real packets
        drive(1'b1, 48'h5, 32'hC5, 1'b0, 1'b0);
        drive(1'b1, 48'h0, 32'hDEAD, 1'b0, 1'b0);
        drive(1'b1, 48'h6, 32'hC6, 1'b0, 1'b0);
        chk("null_level", 64'(level), 64'd2);
        repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("null_hold_addr", 64'(src_addr), 64'h6);
`ifdef SWITCH_INGRESS_STATS_EN
        chk("null_accept", 64'(accept_cnt), 64'd10);
        chk("null_drop", 64'(drop_cnt), 64'd1);
`endif

        // Full with concurrent pop: only the pop happens, push lands next cycle
        for (int k = 0; k < 8; k++)
            drive(1'b1, 48'h10 + 48'(k), 32'hC0 + 32'(k), 1'b0, 1'b0);
        chk("full_level", 64'(level), 64'd8);
        drive(1'b1, 48'h20, 32'hD0, 1'b1, 1'b0);
        chk("fullpop_level", 64'(level), 64'd7);
        chk("fullpop_in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 48'h20, 32'hD0, 1'b0, 1'b0);
        chk("fullpop_push_level", 64'(level), 64'd8);
        repeat (8) drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("fullpop_drain", 64'(level), 64'd0);
        chk("fullpop_last_addr", 64'(src_addr), 64'h20);

        // 20-packet stream with the sink toggling every cycle
        i = 0;
        cyc = 0;
        sr = 1'b1;
        while (i < 20 && cyc < 200) begin
            if (mdl_level < DEPTH) begin
                drive(1'b1, 48'h100 + 48'(i), 32'hB000 + 32'(i), sr, 1'b0);
                i++;
            end else begin
                drive(1'b0, '0, '0, sr, 1'b0);
            end
            sr = ~sr;
            cyc++;
        end
        cyc = 0;
        while (mdl_level != 0 && cyc < 100) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            cyc++;
        end
        chk("wrap_sent", 64'(i), 64'd20);
        chk("wrap_level", 64'(level), 64'd0);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("wrap_last_addr", 64'(src_addr), 64'h113);

        // Flush at level 5 with a packet offered in the same cycle
        for (int k = 0; k < 5; k++)
            drive(1'b1, 48'h200 + 48'(k), 32'hE0 + 32'(k), 1'b0, 1'b0);
        chk("flush_pre_level", 64'(level), 64'd5);
        drive(1'b1, 48'h299, 32'hFF, 1'b0, 1'b1);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_src_valid", 64'(src_valid), 64'd0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("flush_not_stored", 64'(level), 64'd0);
`ifdef SWITCH_INGRESS_STATS_EN
        chk("flush_accept", 64'(accept_cnt), 64'd44);
        chk("flush_drop", 64'(drop_cnt), 64'd1);
`endif

        // Reset while packets are queued
        for (int k = 0; k < 3; k++)
            drive(1'b1, 48'h300 + 48'(k), 32'hF0 + 32'(k), 1'b0, 1'b0);
        chk("midrst_pre_level", 64'(level), 64'd3);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        reset = 1'b0;
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_src_addr", 64'(src_addr), 64'd0);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("midrst_src_valid", 64'(src_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
